// File: rtl/fir_cfg_pkg.sv
// Shared configuration for the reconfigurable FIR path: sizes, controller states,
// and the SRAM-side port bundle driven by the coefficient sequencer.
package fir_cfg_pkg;

    localparam int NUM_COEFF  = 33;
    localparam int BANK_DEPTH = 10;
    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 4;
    localparam int NUM_W      = 6;

    localparam logic [NUM_W-1:0] LAST_COEFF = NUM_W'(NUM_COEFF - 1);
    localparam logic [NUM_W-1:0] LAST_READ  = NUM_W'(BANK_DEPTH - 1);
    localparam logic [NUM_W-1:0] NUM_FULL   = NUM_W'(NUM_COEFF);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        UPDATE,
        WRITE,
        RUN,
        READ
    } fir_state_e;

    typedef struct packed {
        logic              flag;
        logic              csn;
        logic              wrn;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wrdt;
        logic [NUM_W-1:0]  num;
    } ram_port_t;

    localparam ram_port_t PORT_IDLE = '{flag: 1'b0, csn: 1'b1, wrn: 1'b1,
                                        addr: '0, wrdt: '0, num: '0};

    // Banks are 1-based in address: coefficient k lands at (k mod BANK_DEPTH)+1.
    function automatic logic [ADDR_W-1:0] bank_addr(input logic [NUM_W-1:0] k);
        logic [NUM_W-1:0] r;
        r = k % NUM_W'(BANK_DEPTH);
        return ADDR_W'(r) + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/fir_coeff_buffer.sv
// Local coefficient store: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; a load always rewrites every entry.
module fir_coeff_buffer
    import fir_cfg_pkg::*;
(
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [NUM_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [NUM_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [NUM_COEFF];

    always_ff @(posedge clk_i) begin
        if (we_i && (waddr_i <= LAST_COEFF)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = (raddr_i <= LAST_COEFF) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/fir_coeff_sequencer.sv
// Loads FIR coefficients from the host, writes them into the filter's banked SRAMs,
// then issues one BANK_DEPTH-long read window per 600 kHz sample strobe.
module fir_coeff_sequencer
    import fir_cfg_pkg::*;
(
    input  logic              iClk_12M,
    input  logic              iRsn,
    input  logic              iEnSample_600k,
    input  logic              iLoadStart,
    input  logic              iCoeffValid,
    input  logic [DATA_W-1:0] iCoeffData,
    output logic              oCoeffReady,
    output logic              oLoadBusy,
    output logic              oLoadDone,
    output logic              oSampleOverrun,
    output logic              oCoeffiUpdateFlag,
    output logic              oCsnRam,
    output logic              oWrnRam,
    output logic [ADDR_W-1:0] oAddrRam,
    output logic [DATA_W-1:0] oWrDtRam,
    output logic [NUM_W-1:0]  oNumOfCoeff
);

    fir_state_e        state_q, state_d;
    logic [NUM_W-1:0]  k_q, k_d;
    logic              pend_q, pend_d;
    logic              ovr_q, ovr_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    ram_port_t         port_q, port_d;
    logic [DATA_W-1:0] buf_rdata;

    // Read port follows k_d so the registered WrDt lines up with the registered address.
    fir_coeff_buffer u_buf (
        .clk_i   (iClk_12M),
        .we_i    (ready_q && iCoeffValid),
        .waddr_i (k_q),
        .wdata_i (iCoeffData),
        .raddr_i (k_d),
        .rdata_o (buf_rdata)
    );

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            state_q <= IDLE;
            k_q     <= '0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            port_q  <= PORT_IDLE;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            port_q  <= port_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        pend_d  = pend_q;
        ovr_d   = ovr_q;

        case (state_q)
            IDLE: begin
                if (iLoadStart) begin
                    state_d = FILL;
                    k_d     = '0;
                    ovr_d   = 1'b0;
                end
            end
            FILL: begin
                if (iCoeffValid) begin
                    if (k_q == LAST_COEFF) begin
                        state_d = UPDATE;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + NUM_W'(1);
                    end
                end
            end
            UPDATE: begin
                state_d = WRITE;
                k_d     = '0;
            end
            WRITE: begin
                if (k_q == LAST_COEFF) begin
                    state_d = RUN;
                    k_d     = '0;
                end else begin
                    k_d = k_q + NUM_W'(1);
                end
            end
            RUN: begin
                // A load request beats a coincident strobe; that strobe is simply dropped.
                if (iLoadStart) begin
                    state_d = FILL;
                    k_d     = '0;
                    ovr_d   = 1'b0;
                end else if (iEnSample_600k) begin
                    state_d = READ;
                    k_d     = '0;
                end
            end
            READ: begin
                if (iEnSample_600k) ovr_d = 1'b1;
                if (iLoadStart)     pend_d = 1'b1;
                if (k_q == LAST_READ) begin
                    k_d = '0;
                    if (pend_q || iLoadStart) begin
                        state_d = FILL;
                        pend_d  = 1'b0;
                        ovr_d   = 1'b0;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    k_d = k_q + NUM_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
            end
        endcase

        // Filter-side outputs are registered from the next state so each port value
        // appears in the same cycle the FSM enters the corresponding state.
        port_d      = PORT_IDLE;
        port_d.num  = port_q.num;
        case (state_d)
            UPDATE: begin
                port_d.flag = 1'b1;
                port_d.num  = '0;
            end
            WRITE: begin
                port_d.flag = 1'b1;
                port_d.csn  = 1'b0;
                port_d.wrn  = 1'b0;
                port_d.addr = bank_addr(k_d);
                port_d.wrdt = buf_rdata;
                port_d.num  = k_d;
            end
            RUN: begin
                port_d.num = NUM_FULL;
            end
            READ: begin
                port_d.csn  = 1'b0;
                port_d.addr = ADDR_W'(k_d) + ADDR_W'(1);
                port_d.num  = NUM_FULL;
            end
            default: ;
        endcase

        ready_d = (state_d == FILL);
        busy_d  = (state_d == FILL) || (state_d == UPDATE) || (state_d == WRITE);
        done_d  = (state_q == WRITE) && (state_d == RUN);
    end

    assign oCoeffReady       = ready_q;
    assign oLoadBusy         = busy_q;
    assign oLoadDone         = done_q;
    assign oSampleOverrun    = ovr_q;
    assign oCoeffiUpdateFlag = port_q.flag;
    assign oCsnRam           = port_q.csn;
    assign oWrnRam           = port_q.wrn;
    assign oAddrRam          = port_q.addr;
    assign oWrDtRam          = port_q.wrdt;
    assign oNumOfCoeff       = port_q.num;

endmodule

// File: tb/tb_fir_coeff_sequencer.sv
// Scoreboarded bench for fir_coeff_sequencer: stimulus queues expected SRAM accesses,
// a negedge monitor pops and compares every access the DUT presents.
module tb_fir_coeff_sequencer;

    typedef struct packed {
        logic        wrn;
        logic [3:0]  addr;
        logic [15:0] data;
        logic [5:0]  num;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        ld = 1'b0;
    logic        vld = 1'b0;
    logic [15:0] din = '0;
    logic        ready, busy, done, ovr, flag, csn, wrn;
    logic [3:0]  addr;
    logic [15:0] wrdt;
    logic [5:0]  num;

    int   vec = 0, err = 0, mvec = 0, merr = 0;
    acc_t exp_q[$];
    acc_t mon_e, mon_a;
    logic [15:0] kaiser [33];

    fir_coeff_sequencer dut (
        .iClk_12M          (clk),
        .iRsn              (rst_n),
        .iEnSample_600k    (en),
        .iLoadStart        (ld),
        .iCoeffValid       (vld),
        .iCoeffData        (din),
        .oCoeffReady       (ready),
        .oLoadBusy         (busy),
        .oLoadDone         (done),
        .oSampleOverrun    (ovr),
        .oCoeffiUpdateFlag (flag),
        .oCsnRam           (csn),
        .oWrnRam           (wrn),
        .oAddrRam          (addr),
        .oWrDtRam          (wrdt),
        .oNumOfCoeff       (num)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // Monitor: every cycle with Csn low must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && csn == 1'b0) begin
            mvec++;
            if (exp_q.size() == 0) begin
                merr++;
                $display("FAIL unexpected_access: got wrn=%0d addr=%0d num=%0d, expected no access",
                         wrn, addr, num);
            end else begin
                mon_e = exp_q.pop_front();
                mon_a.wrn  = wrn;
                mon_a.addr = addr;
                mon_a.data = mon_e.wrn ? 16'h0 : wrdt;
                mon_a.num  = num;
                if (mon_a !== mon_e || (!mon_e.wrn && flag !== 1'b1)) begin
                    merr++;
                    $display("FAIL sram_access: got wrn=%0d addr=%0d data=%h num=%0d flag=%0d, expected wrn=%0d addr=%0d data=%h num=%0d",
                             mon_a.wrn, mon_a.addr, mon_a.data, mon_a.num, flag,
                             mon_e.wrn, mon_e.addr, mon_e.data, mon_e.num);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] coef(input int set, input int i);
        case (set)
            0:       return kaiser[i];
            1:       return 16'(i * 37 - 500);
            2:       return 16'(32'h8000 + i);
            default: return 16'(32'h7FFF - i);
        endcase
    endfunction

    function automatic acc_t mk_wr(input int k, input logic [15:0] d);
        acc_t e;
        e.wrn  = 1'b0;
        e.addr = 4'((k % 10) + 1);
        e.data = d;
        e.num  = 6'(k);
        return e;
    endfunction

    function automatic acc_t mk_rd(input int j);
        acc_t e;
        e.wrn  = 1'b1;
        e.addr = 4'(j);
        e.data = 16'h0;
        e.num  = 6'd33;
        return e;
    endfunction

    // Full load: optional start pulse, stream 33 beats, then watch UPDATE/WRITE/done.
    task automatic do_load(input int set, input bit send_start, input bit with_strobe,
                           input bit toggle, input int abort_k);
        int k = 0, guard = 0, fc = 0, dc = 0;
        bit acc, idle_ph = 0;
        if (send_start) begin
            ld = 1'b1;
            en = with_strobe;
            tick();
            ld = 1'b0;
            en = 1'b0;
            if (with_strobe) begin
                chk("load_wins_ready", ready, 1);
                chk("load_wins_ovr", ovr, 0);
            end
        end
        while (k < 33 && guard < 300) begin
            guard++;
            en = 1'b0;
            if (toggle && idle_ph) begin
                vld = 1'b0;
                din = 16'hDEAD;
                en  = (k % 4 == 1);
                tick();
                idle_ph = 0;
            end else begin
                vld = 1'b1;
                din = coef(set, k);
                @(negedge clk);
                acc = ready;
                tick();
                if (acc) begin
                    exp_q.push_back(mk_wr(k, coef(set, k)));
                    k++;
                    idle_ph = 1;
                end
            end
        end
        vld = 1'b0;
        en  = 1'b0;
        din = 16'h0;
        if (k < 33) chk("fill_timeout", k, 33);
        if (toggle) chk("fill_strobe_ovr", ovr, 0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (flag) fc++;
            if (done) dc++;
            if (i == 0) begin
                chk("update_flag", flag, 1);
                chk("update_csn", csn, 1);
            end
            if (i == 1) begin
                chk("first_write_csn", csn, 0);
                chk("first_write_addr", addr, 1);
                chk("first_write_data", wrdt, coef(set, 0));
            end
            if (set == 0 && i == 17) begin
                chk("k16_addr", addr, 7);
                chk("k16_data", wrdt, 16'h01F4);
            end
            if (set == 0 && i == 33) begin
                chk("k32_addr", addr, 3);
                chk("k32_data", wrdt, 16'h0003);
            end
            if (abort_k >= 0 && i == abort_k + 1) begin
                chk("abort_at_k", num, abort_k);
                #2;
                rst_n = 1'b0;
                exp_q.delete();
                #1;
                chk("async_rst_csn", csn, 1);
                chk("async_rst_wrn", wrn, 1);
                chk("async_rst_flag", flag, 0);
                chk("async_rst_busy", busy, 0);
                tick();
                tick();
                rst_n = 1'b1;
                return;
            end
        end
        chk("flag_cycles", fc, 34);
        chk("done_pulses", dc, 1);
        chk("num_after_load", num, 33);
        chk("busy_after_load", busy, 0);
        tick();
    endtask

    // One 20-clock sample period; optional second strobe at offset second_at.
    task automatic sample_period(input int second_at, input bit exp_ovr);
        int lows = 0;
        en = 1'b1;
        for (int j = 1; j <= 10; j++) exp_q.push_back(mk_rd(j));
        tick();
        for (int c = 1; c < 20; c++) begin
            en = (c == second_at);
            @(negedge clk);
            if (c == 1) begin
                chk("read_first_csn", csn, 0);
                chk("read_first_addr", addr, 1);
            end
            if (c == 10) chk("read_last_addr", addr, 10);
            if (c == 11) chk("read_end_addr", addr, 0);
            if (!csn) lows++;
            tick();
        end
        en = 1'b0;
        chk("read_window_len", lows, 10);
        chk("overrun_flag", ovr, exp_ovr);
    endtask

    initial begin : main
        int half[17] = '{3, 0, -6, 0, 13, 0, -26, 0, 47, 0, -81, 0, 135, 0, -236, 0, 500};
        int lows, ready_at;
        for (int i = 0; i < 17; i++) begin
            kaiser[i]      = 16'(half[i]);
            kaiser[32 - i] = 16'(half[i]);
        end

        // Reset state
        tick();
        tick();
        @(negedge clk);
        chk("rst_csn", csn, 1);
        chk("rst_wrn", wrn, 1);
        chk("rst_flag", flag, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wrdt", wrdt, 0);
        chk("rst_num", num, 0);
        chk("rst_ready", ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovr", ovr, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_csn", csn, 1);
        chk("idle_ready", ready, 0);
        tick();

        // Load 1: Kaiser taps, host always valid
        do_load(0, 1, 0, 0, -1);

        // Regular 600 kHz operation
        repeat (3) sample_period(-1, 0);

        // Strobe during READ: no restart, sticky overrun
        sample_period(5, 1);

        // Load request mid-window: window completes, then FILL, overrun clears
        en = 1'b1;
        for (int j = 1; j <= 10; j++) exp_q.push_back(mk_rd(j));
        tick();
        en = 1'b0;
        lows = 0;
        ready_at = -1;
        for (int c = 1; c <= 30 && ready_at < 0; c++) begin
            ld = (c == 4);
            @(negedge clk);
            if (c == 4) chk("ovr_sticky_mid_window", ovr, 1);
            if (ready) begin
                ready_at = c;
                chk("ovr_cleared_in_fill", ovr, 0);
            end
            if (!csn) lows++;
            tick();
        end
        ld = 1'b0;
        chk("pending_fill_at", ready_at, 11);
        chk("pending_window_len", lows, 10);

        // Load 2 from FILL, host valid toggling, strobes in FILL ignored
        do_load(1, 0, 0, 1, -1);
        sample_period(-1, 0);

        // Load 3 started with a coincident strobe, aborted by reset at k=12
        do_load(2, 1, 1, 0, 12);
        @(negedge clk);
        chk("post_rst_num", num, 0);
        chk("post_rst_ready", ready, 0);
        tick();

        // Fresh load after the partial table
        do_load(3, 1, 0, 0, -1);
        sample_period(-1, 0);

        repeat (3) tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        vec += mvec;
        err += merr;
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
